// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one combinational ALU, one operation in flight at a time.
// Optional macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins contention and there is no last-grant register.
module alu_arbiter #(
    parameter int n = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*n-1:0] req_A,
    input  logic [2*n-1:0] req_B,
    input  logic [7:0]     req_ALUSel,
    output logic [n-1:0]   alu_A,
    output logic [n-1:0]   alu_B,
    output logic [3:0]     alu_ALUSel,
    input  logic [n-1:0]   alu_ALUResult,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [n-1:0]   rsp_Result,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [n-1:0]   a_q, a_d;
    logic [n-1:0]   b_q, b_d;
    logic [3:0]     sel_q, sel_d;
    logic [n-1:0]   result_q, result_d;
    logic           owner_q, owner_d;
    logic [1:0]     grant;
    logic           grant_idx;
    logic           accept;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = 2'b00;
        if (req_valid[0]) begin
            grant = 2'b01;
        end else if (req_valid[1]) begin
            grant = 2'b10;
        end
    end
`else
    logic last_q, last_d;

    // last_q holds the index of the most recently granted port; contention goes to the other one.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign grant_idx = grant[1];
    // Gating with rst_n keeps req_ready low for the whole time reset is held.
    assign req_ready = ((state_q == IDLE) && rst_n) ? grant : 2'b00;
    assign accept    = |req_ready;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        result_d  = result_q;
        owner_d   = owner_q;
        rsp_valid = 2'b00;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = grant_idx ? req_A[n +: n]      : req_A[0 +: n];
                    b_d     = grant_idx ? req_B[n +: n]      : req_B[0 +: n];
                    sel_d   = grant_idx ? req_ALUSel[4 +: 4] : req_ALUSel[0 +: 4];
                    owner_d = grant_idx;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_ALUResult;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid = owner_q ? 2'b10 : 2'b01;
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            result_q <= '0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            owner_q  <= owner_d;
        end
    end

    assign alu_A      = a_q;
    assign alu_B      = b_q;
    assign alu_ALUSel = sel_q;
    assign rsp_Result = result_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors for alu_arbiter, checked every cycle against a transaction-level model.
// Honours ALU_ARB_FIXED_PRIO_EN the same way the design does.
module tb_alu_arbiter;

    localparam int N = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [1:0]     req_valid = 2'b00;
    logic [1:0]     req_ready;
    logic [2*N-1:0] req_A = '0;
    logic [2*N-1:0] req_B = '0;
    logic [7:0]     req_ALUSel = '0;
    logic [N-1:0]   alu_A, alu_B, alu_ALUResult, rsp_Result;
    logic [3:0]     alu_ALUSel;
    logic [1:0]     rsp_valid;
    logic [1:0]     rsp_ready = 2'b00;
    logic           busy;

    int n_vectors = 0;
    int n_miscompares = 0;
    bit keep_valid = 1'b0;
    int grant_log[$];
    int rsp_port_log[$];
    logic [N-1:0] rsp_data_log[$];

    always #5 clk = ~clk;

    alu_arbiter #(.n(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .req_ALUSel(req_ALUSel),
        .alu_A(alu_A), .alu_B(alu_B), .alu_ALUSel(alu_ALUSel),
        .alu_ALUResult(alu_ALUResult),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_Result(rsp_Result),
        .busy(busy)
    );

    // Stand-in for the shared ALU; unknown select codes produce ~A.
    function automatic logic [N-1:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic [3:0] sel);
        case (sel)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    assign alu_ALUResult = alu_model(alu_A, alu_B, alu_ALUSel);

    function automatic logic [1:0] arb_expect(input logic [1:0] v, input int last);
        if (v != 2'b11) return v;
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 2'b01;
`else
        return (last == 0) ? 2'b10 : 2'b01;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [3:0] sel);
        req_A[port*N +: N]    = a;
        req_B[port*N +: N]    = b;
        req_ALUSel[port*4 +: 4] = sel;
        req_valid[port]       = 1'b1;
    endtask

    // Runs n cycles, logging grants and consumed responses; granted requests drop valid unless keep_valid.
    task automatic runCycles(input int n);
        logic [1:0] drop;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drop = 2'b00;
            if (rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        grant_log.push_back(i);
                        if (!keep_valid) drop[i] = 1'b1;
                    end
                    if (rsp_valid[i] && rsp_ready[i]) begin
                        rsp_port_log.push_back(i);
                        rsp_data_log.push_back(rsp_Result);
                    end
                end
            end
            @(posedge clk);
            #1;
            req_valid = req_valid & ~drop;
        end
    endtask

    task automatic clearLogs();
        grant_log.delete();
        rsp_port_log.delete();
        rsp_data_log.delete();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset req_ready", req_ready, 2'b00);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset rsp_valid", rsp_valid, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int q_int(input int q[$], input int idx);
        return (idx < q.size()) ? q[idx] : -1;
    endfunction

    function automatic logic [N-1:0] q_data(input logic [N-1:0] q[$], input int idx);
        return (idx < q.size()) ? q[idx] : 'x;
    endfunction

    // Transaction model: an accepted operation spends one cycle executing, then responds until consumed.
    initial begin
        int m_active, m_phase, m_owner, m_last;
        logic [N-1:0] m_a, m_b, m_res, m_pending;
        logic [3:0]   m_sel;
        logic [1:0]   exp_ready, exp_rspv;
        m_active = 0; m_phase = 0; m_owner = 0; m_last = 1;
        m_a = '0; m_b = '0; m_res = '0; m_pending = '0; m_sel = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checkOutput("req_ready", req_ready, 2'b00);
                checkOutput("rsp_valid", rsp_valid, 2'b00);
                checkOutput("busy", busy, 1'b0);
                checkOutput("alu_A", alu_A, '0);
                checkOutput("alu_B", alu_B, '0);
                checkOutput("alu_ALUSel", alu_ALUSel, '0);
                checkOutput("rsp_Result", rsp_Result, '0);
                m_active = 0; m_phase = 0; m_owner = 0; m_last = 1;
                m_a = '0; m_b = '0; m_res = '0; m_sel = '0;
            end else begin
                exp_ready = 2'b00;
                exp_rspv  = 2'b00;
                if (m_active == 0) exp_ready = arb_expect(req_valid, m_last);
                else if (m_phase == 1) exp_rspv = (m_owner == 1) ? 2'b10 : 2'b01;
                checkOutput("req_ready", req_ready, exp_ready);
                checkOutput("rsp_valid", rsp_valid, exp_rspv);
                checkOutput("busy", busy, (m_active != 0));
                checkOutput("alu_A", alu_A, m_a);
                checkOutput("alu_B", alu_B, m_b);
                checkOutput("alu_ALUSel", alu_ALUSel, m_sel);
                checkOutput("rsp_Result", rsp_Result, m_res);
                if (m_active == 0 && exp_ready != 2'b00) begin
                    m_owner   = exp_ready[1] ? 1 : 0;
                    m_a       = req_A[m_owner*N +: N];
                    m_b       = req_B[m_owner*N +: N];
                    m_sel     = req_ALUSel[m_owner*4 +: 4];
                    m_pending = alu_model(m_a, m_b, m_sel);
                    m_last    = m_owner;
                    m_active  = 1;
                    m_phase   = 0;
                end else if (m_active != 0 && m_phase == 0) begin
                    m_res   = m_pending;
                    m_phase = 1;
                end else if (m_active != 0 && rsp_ready[m_owner]) begin
                    m_active = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1;
        req_valid = 2'b01;
        doReset();
        req_valid = 2'b00;

        // Single operation from port 0: 5 + 3, response two cycles after the handshake.
        rsp_ready = 2'b00;
        applyStimulus(0, 32'd5, 32'd3, 4'b0000);
        @(negedge clk);
        checkOutput("first req_ready", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        checkOutput("exec rsp_valid", rsp_valid, 2'b00);
        checkOutput("exec busy", busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("latency rsp_valid", rsp_valid, 2'b01);
        checkOutput("5+3 result", rsp_Result, 32'd8);
        @(posedge clk);
        #1;
        rsp_ready = 2'b01;
        runCycles(2);

        // Contention straight after reset: port 0 first.
        doReset();
        rsp_ready = 2'b11;
        clearLogs();
        applyStimulus(0, 32'd10, 32'd4, 4'b0001);
        applyStimulus(1, 32'd1, 32'd1, 4'b0000);
        runCycles(8);
        checkOutput("contention rsp count", rsp_port_log.size(), 2);
        checkOutput("contention first port", q_int(rsp_port_log, 0), 0);
        checkOutput("contention first data", q_data(rsp_data_log, 0), 32'd6);
        checkOutput("contention second port", q_int(rsp_port_log, 1), 1);
        checkOutput("contention second data", q_data(rsp_data_log, 1), 32'd2);

        // Backpressured response with an undecoded select and a waiting port 1 request.
        rsp_ready = 2'b00;
        clearLogs();
        applyStimulus(0, 32'h0000_0F0F, 32'h0000_00FF, 4'hF);
        runCycles(2);
        applyStimulus(1, 32'd100, 32'd23, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("hold rsp_valid", rsp_valid, 2'b01);
            checkOutput("hold rsp_Result", rsp_Result, 32'hFFFF_F0F0);
            checkOutput("hold req_ready", req_ready, 2'b00);
            checkOutput("hold alu_ALUSel", alu_ALUSel, 4'hF);
            @(posedge clk);
            #1;
        end
        rsp_ready = 2'b11;
        runCycles(6);
        checkOutput("hold grant count", grant_log.size(), 2);
        checkOutput("hold second grant", q_int(grant_log, 1), 1);
        checkOutput("hold port1 data", q_data(rsp_data_log, 1), 32'd123);

        // A request withdrawn while the block is busy is never granted.
        rsp_ready = 2'b00;
        clearLogs();
        applyStimulus(0, 32'd3, 32'd4, 4'd3);
        runCycles(2);
        applyStimulus(1, 32'd9, 32'd9, 4'd0);
        runCycles(2);
        req_valid[1] = 1'b0;
        rsp_ready = 2'b11;
        runCycles(4);
        checkOutput("withdraw grant count", grant_log.size(), 1);
        checkOutput("withdraw data", q_data(rsp_data_log, 0), 32'd7);

        // Reset pulse during EXEC aborts the operation.
        clearLogs();
        applyStimulus(0, 32'd20, 32'd22, 4'd1);
        runCycles(1);
        checkOutput("abort grant count", grant_log.size(), 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort busy", busy, 1'b0);
        checkOutput("abort rsp_valid", rsp_valid, 2'b00);
        checkOutput("abort alu_A", alu_A, 32'd0);
        checkOutput("abort rsp_Result", rsp_Result, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        runCycles(5);
        checkOutput("abort no response", rsp_port_log.size(), 0);
        clearLogs();
        applyStimulus(0, 32'd2, 32'd2, 4'd0);
        applyStimulus(1, 32'd4, 32'd4, 4'd0);
        runCycles(1);
        checkOutput("post-abort winner", q_int(grant_log, 0), 0);
        runCycles(8);

        // Continuous requests from both ports.
        doReset();
        clearLogs();
        rsp_ready = 2'b11;
        keep_valid = 1'b1;
        applyStimulus(0, 32'd11, 32'd1, 4'd0);
        applyStimulus(1, 32'd22, 32'd2, 4'd1);
        runCycles(12);
        keep_valid = 1'b0;
        req_valid = 2'b00;
        runCycles(4);
        checkOutput("stream grant count", grant_log.size(), 4);
`ifdef ALU_ARB_FIXED_PRIO_EN
        checkOutput("stream grant 0", q_int(grant_log, 0), 0);
        checkOutput("stream grant 1", q_int(grant_log, 1), 0);
        checkOutput("stream grant 2", q_int(grant_log, 2), 0);
        checkOutput("stream grant 3", q_int(grant_log, 3), 0);
`else
        checkOutput("stream grant 0", q_int(grant_log, 0), 0);
        checkOutput("stream grant 1", q_int(grant_log, 1), 1);
        checkOutput("stream grant 2", q_int(grant_log, 2), 0);
        checkOutput("stream grant 3", q_int(grant_log, 3), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
